adc_readout_sequencer: RTL and testbench

- Sequences readout of the four per-channel circular sample RAMs filled by the ADC acquisition block once a capture has completed.
- Computes the window start from the trigger write address and the pre-trigger depth, then walks the RAM with wrap-around, channel by channel.
- Streams bytes to the host serializer over a valid/ready handshake.
- Re-arms acquisition by pulsing startTrigger when readout is finished.

---
 rtl/adc_readout_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_adc_readout_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_sequencer.sv
// rtl/adc_readout_sequencer.sv - reads captured ADC windows out of the circular sample RAMs as a byte stream
module adc_readout_sequencer #(
  parameter int ram_width = 10,
  parameter int RDLAT     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_readout,
  input  logic                 abort,
  input  logic                 rearm_en,
  input  logic                 data_ready,
  input  logic [ram_width-1:0] wraddress_triggerpoint,
  input  logic [ram_width-1:0] pretrig,
  input  logic [ram_width:0]   num_samples,
  input  logic [3:0]           chan_mask,
  output logic                 rden,
  output logic [ram_width-1:0] rdaddress,
  input  logic [7:0]           ram_q1,
  input  logic [7:0]           ram_q2,
  input  logic [7:0]           ram_q3,
  input  logic [7:0]           ram_q4,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 startTrigger,
  output logic                 busy,
  output logic                 done
);

  // Full RAM depth expressed in the sample-count width.
  localparam logic [ram_width:0] depth = {1'b1, {ram_width{1'b0}}};
  localparam logic [1:0] lat_last = 2'(RDLAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAITRDY,
    READ,
    LAT,
    PUSH,
    FINISH
  } state_t;

  state_t state, state_next;

  // Settings captured when a readout request is accepted.
  logic [ram_width-1:0] trig_q;
  logic [ram_width-1:0] pretrig_q;
  logic [ram_width:0]   nsamp_q;
  logic [3:0]           mask_q;

  // Walk position within the current channel.
  logic [ram_width-1:0] addr;
  logic [ram_width:0]   left;
  logic [1:0]           chan;
  logic [1:0]           lat_cnt;

  logic [ram_width-1:0] win_start;
  logic [ram_width:0]   eff_samples;
  logic                 lat_done;
  logic                 last_of_chan;
  logic [1:0]           first_chan;
  logic                 first_found;
  logic [1:0]           next_chan;
  logic                 next_found;
  logic [7:0]           q_sel;

  // Window start wraps naturally in the RAM address width; a zero or oversize count means a full RAM.
  always_comb begin
    win_start    = trig_q - pretrig_q;
    eff_samples  = ((nsamp_q == '0) || (nsamp_q > depth)) ? depth : nsamp_q;
    lat_done     = (lat_cnt == lat_last);
    last_of_chan = (left == {{ram_width{1'b0}}, 1'b1});
  end

  // Lowest set channel overall, and lowest set channel above the current one.
  always_comb begin
    first_found = 1'b0;
    first_chan  = 2'd0;
    next_found  = 1'b0;
    next_chan   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_found = 1'b1;
        first_chan  = 2'(i);
      end
      if (mask_q[i] && (i > int'(chan))) begin
        next_found = 1'b1;
        next_chan  = 2'(i);
      end
    end
  end

  // Route the RAM of the channel being walked to the capture register.
  always_comb begin
    q_sel = ram_q1;
    case (chan)
      2'd0: q_sel = ram_q1;
      2'd1: q_sel = ram_q2;
      2'd2: q_sel = ram_q3;
      2'd3: q_sel = ram_q4;
      default: q_sel = ram_q1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived strobes; abort overrides every transition.
  always_comb begin
    state_next   = state;
    rden         = 1'b0;
    done         = 1'b0;
    startTrigger = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_readout) state_next = WAITRDY;
      end
      WAITRDY: begin
        if (data_ready) state_next = (mask_q == 4'd0) ? FINISH : READ;
      end
      READ: begin
        rden       = 1'b1;
        state_next = LAT;
      end
      LAT: begin
        if (lat_done) state_next = PUSH;
      end
      PUSH: begin
        if (out_ready) begin
          state_next = (last_of_chan && !next_found) ? FINISH : READ;
        end
      end
      FINISH: begin
        done         = !abort;
        startTrigger = !abort && rearm_en;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Datapath: input latching, address walk, latency count and output byte register.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q    <= '0;
      pretrig_q <= '0;
      nsamp_q   <= '0;
      mask_q    <= '0;
      addr      <= '0;
      left      <= '0;
      chan      <= '0;
      lat_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_readout) begin
            trig_q    <= wraddress_triggerpoint;
            pretrig_q <= pretrig;
            nsamp_q   <= num_samples;
            mask_q    <= chan_mask;
          end
        end
        WAITRDY: begin
          if (data_ready && first_found) begin
            chan <= first_chan;
            addr <= win_start;
            left <= eff_samples;
          end
        end
        READ: begin
          lat_cnt <= '0;
        end
        LAT: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_done) begin
            out_data  <= q_sel;
            out_valid <= 1'b1;
          end
        end
        PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            left      <= left - 1'b1;
            addr      <= addr + 1'b1;
            // Channel exhausted: jump to the next requested channel at the window start.
            if (last_of_chan && next_found) begin
              chan <= next_chan;
              addr <= win_start;
              left <= eff_samples;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rdaddress = addr;

endmodule

// File: tb/tb_adc_readout_sequencer.sv
// tb/tb_adc_readout_sequencer.sv - randomized bench with a queue-based readout model
module tb_adc_readout_sequencer;
  localparam int RW    = 10;
  localparam int RDLAT = 2;
  localparam int DEPTH = 1 << RW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_readout = 1'b0;
  logic          abort = 1'b0;
  logic          rearm_en = 1'b0;
  logic          data_ready = 1'b0;
  logic [RW-1:0] wraddress_triggerpoint = '0;
  logic [RW-1:0] pretrig = '0;
  logic [RW:0]   num_samples = '0;
  logic [3:0]    chan_mask = '0;
  logic          rden;
  logic [RW-1:0] rdaddress;
  logic [7:0]    ram_q1, ram_q2, ram_q3, ram_q4;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          startTrigger;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  adc_readout_sequencer #(.ram_width(RW), .RDLAT(RDLAT)) dut (
    .clk(clk), .reset(reset), .start_readout(start_readout), .abort(abort),
    .rearm_en(rearm_en), .data_ready(data_ready),
    .wraddress_triggerpoint(wraddress_triggerpoint), .pretrig(pretrig),
    .num_samples(num_samples), .chan_mask(chan_mask),
    .rden(rden), .rdaddress(rdaddress),
    .ram_q1(ram_q1), .ram_q2(ram_q2), .ram_q3(ram_q3), .ram_q4(ram_q4),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .startTrigger(startTrigger), .busy(busy), .done(done)
  );

  // Sample RAMs with RDLAT cycles from rden/rdaddress to q.
  logic [7:0]    mem [4][DEPTH];
  logic [RW-1:0] addr_pipe [RDLAT];
  always @(posedge clk) begin
    if (rden) addr_pipe[0] <= rdaddress;
    for (int i = 1; i < RDLAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign ram_q1 = mem[0][addr_pipe[RDLAT-1]];
  assign ram_q2 = mem[1][addr_pipe[RDLAT-1]];
  assign ram_q3 = mem[2][addr_pipe[RDLAT-1]];
  assign ram_q4 = mem[3][addr_pipe[RDLAT-1]];

  int n_checks = 0;
  int n_fail = 0;
  int exp_addr[$];
  int exp_data[$];
  bit run_active = 0;
  bit exp_rearm = 0;
  int ready_mode = 0;
  int done_count = 0;
  int acc_total = 0;
  int acc_base = 0;
  int stall_left = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Expected readout: every requested channel in ascending order, each walking
  // the wrapped window that starts pretrig samples before the trigger.
  task automatic build_model(input int trig, input int pre, input int ns, input logic [3:0] m);
    int eff;
    int start;
    eff = (ns == 0 || ns > DEPTH) ? DEPTH : ns;
    start = (trig - pre + DEPTH) % DEPTH;
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int i = 0; i < eff; i++) begin
          exp_addr.push_back((start + i) % DEPTH);
          exp_data.push_back(int'(mem[ch][(start + i) % DEPTH]));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: checks the DUT against the model on every falling edge.
  initial begin
    bit kill_prev = 1;
    bit prev_valid = 0;
    bit prev_ready = 0;
    logic [7:0] prev_data = '0;
    int cyc = 0;
    int last_rise = -1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (kill_prev) begin
        check("killed_out_valid", out_valid, 0);
        check("killed_rden", rden, 0);
        check("killed_busy", busy, 0);
        check("killed_done", done, 0);
        check("killed_start_trigger", startTrigger, 0);
      end else if (prev_valid && !prev_ready) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_out_data", out_data, prev_data);
      end
      if (out_valid) check("rden_during_push", rden, 0);
      if (rden) begin
        if (exp_addr.size() == 0) check("unexpected_rden", 1, 0);
        else check("rdaddress", rdaddress, exp_addr.pop_front());
      end
      if (out_valid && !prev_valid && !kill_prev) begin
        if (ready_mode == 0 && last_rise >= 0) check("byte_spacing", cyc - last_rise, RDLAT + 2);
        last_rise = cyc;
      end
      if (ready_mode != 0) last_rise = -1;
      if (out_valid && out_ready && !reset && !abort) begin
        if (exp_data.size() == 0) check("unexpected_byte", 1, 0);
        else check("out_data", out_data, exp_data.pop_front());
        acc_total++;
      end
      if (startTrigger && !done) check("trigger_without_done", 1, 0);
      if (done) begin
        check("done_in_run", run_active, 1);
        check("done_bytes_left", exp_data.size(), 0);
        check("done_reads_left", exp_addr.size(), 0);
        check("start_trigger", startTrigger, exp_rearm);
        run_active = 0;
        done_count++;
        last_rise = -1;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data = out_data;
      kill_prev = reset || abort;
      if (kill_prev) begin
        exp_addr.delete();
        exp_data.delete();
        run_active = 0;
        last_rise = -1;
      end
    end
  end

  // Downstream ready: always, random, stall at the third byte, or never.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom % 3) != 0;
        2: begin
          if (out_valid && (acc_total - acc_base) == 2 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic start_run(input int trig, input int pre, input int ns, input logic [3:0] m,
                           input bit rearm, input int rdy_delay);
    wraddress_triggerpoint = RW'(trig);
    pretrig = RW'(pre);
    num_samples = (RW+1)'(ns);
    chan_mask = m;
    rearm_en = rearm;
    exp_rearm = rearm;
    start_readout = 1'b1;
    build_model(trig, pre, ns, m);
    run_active = 1;
    acc_base = acc_total;
    tick();
    start_readout = 1'b0;
    wraddress_triggerpoint = RW'($urandom);
    pretrig = RW'($urandom);
    num_samples = (RW+1)'($urandom);
    chan_mask = 4'($urandom);
    repeat (rdy_delay) tick();
    data_ready = 1'b1;
  endtask

  task automatic finish_run(input string name, input int d0);
    int t;
    t = 0;
    while (done_count == d0 && t < 20000) begin
      tick();
      t++;
    end
    if (done_count == d0) check({name, "_timeout"}, 1, 0);
    data_ready = 1'b0;
    tick();
    check({name, "_busy_after"}, busy, 0);
    repeat (3) tick();
    check({name, "_done_once"}, done_count, d0 + 1);
  endtask

  initial begin
    int d0;
    int t;
    for (int ch = 0; ch < 4; ch++)
      for (int a = 0; a < DEPTH; a++) mem[ch][a] = 8'($urandom);
    repeat (3) tick();
    check("reset_out_data", out_data, 0);
    check("reset_rdaddress", rdaddress, 0);
    check("reset_out_valid", out_valid, 0);
    reset = 1'b0;
    tick();

    // Basic window, single channel.
    ready_mode = 0;
    d0 = done_count;
    start_run(100, 20, 4, 4'b0001, 0, 2);
    check("t1_model_len", exp_addr.size(), 4);
    check("t1_first_addr", exp_addr[0], 80);
    check("t1_last_addr", exp_addr[3], 83);
    finish_run("t1", d0);

    // Window wrapping below address 0, channels 2 and 4.
    d0 = done_count;
    start_run(5, 10, 8, 4'b1010, 1, 0);
    check("t2_model_len", exp_addr.size(), 16);
    check("t2_first_addr", exp_addr[0], 1019);
    check("t2_wrap_addr", exp_addr[5], 0);
    check("t2_ch4_addr", exp_addr[8], 1019);
    check("t2_ch4_data", exp_data[8], int'(mem[3][1019]));
    finish_run("t2", d0);

    // Seven-cycle back-pressure on the third byte.
    ready_mode = 2;
    stall_left = 7;
    d0 = done_count;
    start_run(300, 3, 6, 4'b0100, 0, 1);
    finish_run("t3", d0);
    check("t3_stall_used", stall_left, 0);
    ready_mode = 0;

    // Empty mask: finish immediately with re-arm.
    d0 = done_count;
    start_run(7, 7, 5, 4'b0000, 1, 3);
    check("t4_model_len", exp_addr.size(), 0);
    finish_run("t4", d0);

    // Zero count means the full RAM.
    d0 = done_count;
    start_run(10, 0, 0, 4'b0001, 0, 0);
    check("t5_model_len", exp_addr.size(), 1024);
    check("t5_last_before_wrap", exp_addr[1013], 1023);
    check("t5_after_wrap", exp_addr[1014], 0);
    finish_run("t5", d0);

    // Abort while a byte is waiting for acceptance.
    ready_mode = 3;
    d0 = done_count;
    start_run(50, 1, 3, 4'b0100, 1, 0);
    t = 0;
    while (!out_valid && t < 100) begin tick(); t++; end
    check("t6_reached_push", out_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    data_ready = 1'b0;
    ready_mode = 0;
    repeat (5) tick();
    check("t6_no_done", done_count, d0);
    d0 = done_count;
    start_run(51, 2, 3, 4'b0010, 1, 0);
    finish_run("t6_restart", d0);

    // Reset while a read is being issued.
    d0 = done_count;
    start_run(600, 100, 5, 4'b1001, 1, 0);
    t = 0;
    while (!rden && t < 100) begin tick(); t++; end
    check("t7_reached_read", rden, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_ready = 1'b0;
    repeat (5) tick();
    check("t7_no_done", done_count, d0);
    d0 = done_count;
    start_run(600, 100, 5, 4'b1001, 0, 0);
    finish_run("t7_restart", d0);

    // Oversized count also means the full RAM.
    d0 = done_count;
    start_run(1000, 999, 1500, 4'b1000, 0, 0);
    check("t8_model_len", exp_addr.size(), 1024);
    finish_run("t8", d0);

    // Randomized runs with random back-pressure.
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      d0 = done_count;
      start_run(int'($urandom % DEPTH), int'($urandom % DEPTH), int'($urandom_range(1, 12)),
                4'($urandom), bit'($urandom % 2), int'($urandom_range(0, 5)));
      finish_run("rand", d0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
